// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, with the
// trial subtraction done by a ripple chain of full_adder cells (a + ~b + 1).

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t           state;
  logic [WIDTH-1:0] q, d;
  // Stored partial remainder drops bit WIDTH: it is zero after every update.
  logic [WIDTH-1:0] r;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   r_sh, nd, t;
  logic [WIDTH+1:0] c;
  logic             no_borrow;
  logic [WIDTH-1:0] q_next, r_next;

  assign r_sh = {r, q[WIDTH-1]};
  assign nd   = ~{1'b0, d};
  assign c[0] = 1'b1;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_sub
    full_adder u_fa (
      .a   (r_sh[i]),
      .b   (nd[i]),
      .cin (c[i]),
      .sum (t[i]),
      .cout(c[i+1])
    );
  end

  // Carry-out and ~T[WIDTH] agree for every reachable R'/D pair.
  assign no_borrow = ~t[WIDTH] & c[WIDTH+1];
  assign r_next    = no_borrow ? t[WIDTH-1:0] : r_sh[WIDTH-1:0];
  assign q_next    = {q[WIDTH-2:0], no_borrow};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      q           <= '0;
      d           <= '0;
      r           <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        CALC: begin
          q   <= q_next;
          r   <= r_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state     <= FINISH;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= q_next;
            remainder <= r_next;
          end
        end
        default: begin
          // IDLE and FINISH both accept a new request (back-to-back from FINISH).
          state <= IDLE;
          if (start) begin
            if (divisor != '0) begin
              q           <= dividend;
              d           <= divisor;
              r           <= '0;
              cnt         <= '0;
              div_by_zero <= 1'b0;
              busy        <= 1'b1;
              state       <= CALC;
            end else begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= FINISH;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_restoring_divider.sv
// Directed and random checks of restoring_divider; stimulus and sampling on negedge.

module tb_restoring_divider;
  logic       clk, rst, start;
  logic [7:0] dividend, divisor;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient, remainder;

  int checks = 0;
  int errors = 0;

  restoring_divider #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one cycle; returns in the first cycle after acceptance.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0; dividend = 8'($urandom); divisor = 8'($urandom);
  endtask

  // Called in cycle 1 after acceptance; lat is the cycle index where done is seen.
  task automatic wait_done(output int lat, output int bcnt);
    lat = 1; bcnt = 0;
    while (done !== 1'b1 && lat < 30) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL wait_done: done=%b after %0d cycles, required 1", done, lat);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (quotient !== 8'd0) begin errors++; $display("FAIL reset_quotient: got %0d want 0", quotient); end
    checks++; if (remainder !== 8'd0) begin errors++; $display("FAIL reset_remainder: got %0d want 0", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, bcnt;
    start_op(8'd200, 8'd7);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_c1: got %b want 1", busy); end
    wait_done(lat, bcnt);
    checks++; if (lat != 9) begin errors++; $display("FAIL basic_latency: got %0d want 9", lat); end
    checks++; if (bcnt != 8) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 8", bcnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %b want 0", busy); end
    checks++; if (quotient !== 8'd28) begin errors++; $display("FAIL basic_quotient: got %0d want 28", quotient); end
    checks++; if (remainder !== 8'd4) begin errors++; $display("FAIL basic_remainder: got %0d want 4", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL basic_dbz: got %b want 0", div_by_zero); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_boundary();
    logic [7:0] va [4] = '{8'd255, 8'd5, 8'd255, 8'd0};
    logic [7:0] vb [4] = '{8'd1,   8'd9, 8'd255, 8'd3};
    logic [7:0] eq [4] = '{8'd255, 8'd0, 8'd1,   8'd0};
    logic [7:0] er [4] = '{8'd0,   8'd5, 8'd0,   8'd0};
    int lat, bcnt;
    for (int i = 0; i < 4; i++) begin
      start_op(va[i], vb[i]);
      wait_done(lat, bcnt);
      checks++; if (lat != 9) begin errors++; $display("FAIL bound%0d_latency: got %0d want 9", i, lat); end
      checks++; if (quotient !== eq[i]) begin errors++; $display("FAIL bound%0d_quotient: got %0d want %0d", i, quotient, eq[i]); end
      checks++; if (remainder !== er[i]) begin errors++; $display("FAIL bound%0d_remainder: got %0d want %0d", i, remainder, er[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_div_zero();
    int lat, bcnt;
    start_op(8'd100, 8'd0);
    wait_done(lat, bcnt);
    checks++; if (lat != 1) begin errors++; $display("FAIL dz_latency: got %0d want 1", lat); end
    checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b want 1", div_by_zero); end
    checks++; if (quotient !== 8'hFF) begin errors++; $display("FAIL dz_quotient: got %h want ff", quotient); end
    checks++; if (remainder !== 8'd100) begin errors++; $display("FAIL dz_remainder: got %0d want 100", remainder); end
    repeat (3) @(negedge clk);
    checks++; if ({done, div_by_zero, quotient, remainder} !== {1'b0, 1'b1, 8'hFF, 8'd100}) begin
      errors++; $display("FAIL dz_hold: got done=%b dbz=%b q=%h r=%0d want 0 1 ff 100", done, div_by_zero, quotient, remainder);
    end
    start_op(8'd10, 8'd3);
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL dz_clear_on_start: got %b want 0", div_by_zero); end
    wait_done(lat, bcnt);
    checks++; if (quotient !== 8'd3) begin errors++; $display("FAIL dz_next_quotient: got %0d want 3", quotient); end
    checks++; if (remainder !== 8'd1) begin errors++; $display("FAIL dz_next_remainder: got %0d want 1", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL dz_next_flag: got %b want 0", div_by_zero); end
    @(negedge clk);
  endtask

  task automatic test_start_busy();
    int lat, bcnt;
    start_op(8'd200, 8'd7);
    lat = 1;
    repeat (2) begin @(negedge clk); lat++; end
    start = 1'b1; dividend = 8'd9; divisor = 8'd2;
    @(negedge clk); lat++;
    start = 1'b0;
    while (done !== 1'b1 && lat < 30) begin @(negedge clk); lat++; end
    checks++; if (lat != 9) begin errors++; $display("FAIL busy_ignore_latency: got %0d want 9", lat); end
    checks++; if (quotient !== 8'd28) begin errors++; $display("FAIL busy_ignore_quotient: got %0d want 28", quotient); end
    checks++; if (remainder !== 8'd4) begin errors++; $display("FAIL busy_ignore_remainder: got %0d want 4", remainder); end
    // Back-to-back request presented in the done cycle.
    start_op(8'd9, 8'd2);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b want 1", busy); end
    checks++; if (quotient !== 8'd28) begin errors++; $display("FAIL b2b_hold: got %0d want 28", quotient); end
    wait_done(lat, bcnt);
    checks++; if (lat != 9) begin errors++; $display("FAIL b2b_latency: got %0d want 9", lat); end
    checks++; if (quotient !== 8'd4) begin errors++; $display("FAIL b2b_quotient: got %0d want 4", quotient); end
    checks++; if (remainder !== 8'd1) begin errors++; $display("FAIL b2b_remainder: got %0d want 1", remainder); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat, bcnt, ndone;
    start_op(8'd200, 8'd7);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if ({busy, done, quotient, remainder, div_by_zero} !== 19'd0) begin
      errors++; $display("FAIL rstmid_outputs: got busy=%b done=%b q=%0d r=%0d dbz=%b want all 0", busy, done, quotient, remainder, div_by_zero);
    end
    ndone = 0;
    repeat (12) begin if (done !== 1'b0 || busy !== 1'b0) ndone++; @(negedge clk); end
    checks++; if (ndone != 0) begin errors++; $display("FAIL rstmid_no_done: got %0d active cycles want 0", ndone); end
    start_op(8'd50, 8'd6);
    wait_done(lat, bcnt);
    checks++; if (quotient !== 8'd8) begin errors++; $display("FAIL rstmid_quotient: got %0d want 8", quotient); end
    checks++; if (remainder !== 8'd2) begin errors++; $display("FAIL rstmid_remainder: got %0d want 2", remainder); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [7:0] a, b, eq, er;
    int lat, bcnt;
    for (int i = 0; i < 1000; i++) begin
      a  = 8'($urandom_range(0, 255));
      b  = 8'($urandom_range(1, 255));
      eq = a / b;
      er = a % b;
      start_op(a, b);
      wait_done(lat, bcnt);
      checks++;
      if (quotient !== eq || remainder !== er) begin
        errors++; $display("FAIL rand_result %0d/%0d: got q=%0d r=%0d want q=%0d r=%0d", a, b, quotient, remainder, eq, er);
      end
      checks++;
      if ((int'(quotient) * int'(b) + int'(remainder)) != int'(a) || remainder >= b) begin
        errors++; $display("FAIL rand_invariant %0d/%0d: got q=%0d r=%0d", a, b, quotient, remainder);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dividend = 8'd0; divisor = 8'd0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_boundary();
    test_div_zero();
    test_start_busy();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
